// File: rtl/fetch_ctrl_pkg.sv
// fetch_ctrl_pkg: shared types for the fetch controller slice.
//   fetch_state_t : controller state (IDLE, RUN, HALT)
//   fetch_entry_t : one prefetch buffer entry {pc, instr}
//   FETCH_XLEN / FETCH_DEPTH : default word width and buffer depth
package fetch_ctrl_pkg;

    localparam int unsigned FETCH_XLEN  = 32;
    localparam int unsigned FETCH_DEPTH = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [FETCH_XLEN-1:0] pc;
        logic [FETCH_XLEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_buf.sv
// fetch_buf: DEPTH-entry FIFO of fetch_entry_t used as the prefetch buffer.
//   clk, rstn        : clock, asynchronous active-low reset
//   push, push_data  : write one entry (accepted when not full, or full with a pop)
//   pop              : discard the head (ignored when empty)
//   flush            : empty the FIFO; wins over push and pop
//   head             : entry at the head (meaningful only when !empty)
//   count/full/empty : occupancy
import fetch_ctrl_pkg::*;

module fetch_buf #(
    parameter int unsigned DEPTH = FETCH_DEPTH
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       push,
    input  fetch_entry_t               push_data,
    input  logic                       pop,
    input  logic                       flush,
    output fetch_entry_t               head,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    fetch_entry_t  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          pop_ok;
    logic          push_ok;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign head    = mem[rd_ptr];

    // Storage needs no reset: head is only observed while count is non-zero.
    always_ff @(posedge clk) begin
        if (push_ok && !flush) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            unique case ({push_ok, pop_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: sequences the combinational word-indexed fetch stage.
// Owns the fetch PC, issues fetches into a prefetch buffer (fetch_buf) and
// presents buffered words to decode over valid/ready. Trap/branch redirects
// flush the buffer; halt_req stops issue and lets the buffer drain.
//   clk, rstn                  : clock, asynchronous active-low reset
//   start, halt_req            : IDLE->RUN, RUN->HALT requests
//   trap_valid/trap_pc         : highest-priority redirect
//   br_valid/br_pc             : branch/jump redirect
//   fetch_en, fetch_pc         : fetch stage request
//   fetch_instr, fetch_pc_ret  : fetch stage response (same cycle)
//   out_valid/out_ready/out_instr/out_pc : decode handshake
//   busy                       : RUN, or buffer non-empty
// Optional build macro FETCH_CTRL_PERF_EN adds saturating counters
// perf_fetched, perf_stall and perf_flush.
import fetch_ctrl_pkg::*;

module fetch_ctrl #(
    parameter int unsigned XLEN       = FETCH_XLEN,
    parameter int unsigned DEPTH      = FETCH_DEPTH,
    parameter int unsigned RESET_PC   = 0,
    parameter int unsigned IMEM_WORDS = 64
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            start,
    input  logic            halt_req,
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_pc,
    input  logic            br_valid,
    input  logic [XLEN-1:0] br_pc,
    output logic            fetch_en,
    output logic [XLEN-1:0] fetch_pc,
    input  logic [XLEN-1:0] fetch_instr,
    input  logic [XLEN-1:0] fetch_pc_ret,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_instr,
    output logic [XLEN-1:0] out_pc,
    output logic            busy
`ifdef FETCH_CTRL_PERF_EN
    ,
    output logic [31:0]     perf_fetched,
    output logic [31:0]     perf_stall,
    output logic [31:0]     perf_flush
`endif
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    fetch_state_t    state;
    fetch_state_t    state_nxt;
    logic [XLEN-1:0] pc_reg;
    logic [XLEN-1:0] pc_seq;
    logic [XLEN-1:0] redir_pc;
    logic            redirect;
    logic            pop;

    fetch_entry_t    push_data;
    fetch_entry_t    head;
    logic [CW-1:0]   count;
    logic            full;
    logic            empty;

    assign redirect = trap_valid || br_valid;
    assign pop      = out_valid && out_ready;

    // Issue may use the slot freed by a same-cycle pop when full.
    assign fetch_en = (state == RUN) && !redirect && (!full || pop);
    assign fetch_pc = pc_reg;

    // pc_reg is always kept below IMEM_WORDS, so a compare suffices for wrap.
    assign pc_seq   = (pc_reg == XLEN'(IMEM_WORDS - 1)) ? '0 : pc_reg + XLEN'(1);
    assign redir_pc = (trap_valid ? trap_pc : br_pc) % XLEN'(IMEM_WORDS);

    assign push_data.pc    = FETCH_XLEN'(fetch_pc_ret);
    assign push_data.instr = FETCH_XLEN'(fetch_instr);

    assign out_valid = !empty;
    assign out_instr = empty ? '0 : XLEN'(head.instr);
    assign out_pc    = empty ? '0 : XLEN'(head.pc);
    assign busy      = (state == RUN) || (count != '0);

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (!redirect && halt_req) state_nxt = HALT;
            HALT:    if (redirect) state_nxt = RUN;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state  <= IDLE;
            pc_reg <= XLEN'(RESET_PC);
        end else begin
            state <= state_nxt;
            if (redirect) begin
                pc_reg <= redir_pc;
            end else if (fetch_en) begin
                pc_reg <= pc_seq;
            end
        end
    end

    fetch_buf #(
        .DEPTH(DEPTH)
    ) u_buf (
        .clk       (clk),
        .rstn      (rstn),
        .push      (fetch_en),
        .push_data (push_data),
        .pop       (pop),
        .flush     (redirect),
        .head      (head),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

`ifdef FETCH_CTRL_PERF_EN
    logic discard;

    // A popped head is delivered, not discarded; an in-flight word is one
    // that RUN would have issued this cycle had there been no redirect.
    assign discard = redirect &&
                     ((count > CW'(pop)) || ((state == RUN) && (!full || pop)));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            perf_fetched <= '0;
            perf_stall   <= '0;
            perf_flush   <= '0;
        end else begin
            if (fetch_en && (perf_fetched != '1)) begin
                perf_fetched <= perf_fetched + 32'd1;
            end
            if ((state == RUN) && !fetch_en && !redirect && (perf_stall != '1)) begin
                perf_stall <= perf_stall + 32'd1;
            end
            if (discard && (perf_flush != '1)) begin
                perf_flush <= perf_flush + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
module tb_fetch_ctrl;

    localparam int unsigned DEPTH = 2;
    localparam int unsigned WORDS = 64;

    logic        clk;
    logic        rstn;
    logic        start;
    logic        halt_req;
    logic        trap_valid;
    logic [31:0] trap_pc;
    logic        br_valid;
    logic [31:0] br_pc;
    logic        out_ready;

    logic        fetch_en,  fetch_en2;
    logic [31:0] fetch_pc,  fetch_pc2;
    logic [31:0] fetch_instr, fetch_instr2;
    logic [31:0] fetch_pc_ret, fetch_pc_ret2;
    logic        out_valid, out_valid2;
    logic [31:0] out_instr, out_instr2;
    logic [31:0] out_pc,    out_pc2;
    logic        busy,      busy2;

    logic [31:0] imem [WORDS];

    // Combinational fetch stage model shared by both instances.
    assign fetch_instr   = imem[fetch_pc[5:0]];
    assign fetch_pc_ret  = fetch_pc;
    assign fetch_instr2  = imem[fetch_pc2[5:0]];
    assign fetch_pc_ret2 = fetch_pc2;

    fetch_ctrl #(
        .XLEN(32), .DEPTH(DEPTH), .RESET_PC(0), .IMEM_WORDS(WORDS)
    ) dut (
        .clk(clk), .rstn(rstn), .start(start), .halt_req(halt_req),
        .trap_valid(trap_valid), .trap_pc(trap_pc),
        .br_valid(br_valid), .br_pc(br_pc),
        .fetch_en(fetch_en), .fetch_pc(fetch_pc),
        .fetch_instr(fetch_instr), .fetch_pc_ret(fetch_pc_ret),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_pc(out_pc), .busy(busy)
    );

    fetch_ctrl #(
        .XLEN(32), .DEPTH(DEPTH), .RESET_PC(62), .IMEM_WORDS(WORDS)
    ) dut2 (
        .clk(clk), .rstn(rstn), .start(start), .halt_req(halt_req),
        .trap_valid(trap_valid), .trap_pc(trap_pc),
        .br_valid(br_valid), .br_pc(br_pc),
        .fetch_en(fetch_en2), .fetch_pc(fetch_pc2),
        .fetch_instr(fetch_instr2), .fetch_pc_ret(fetch_pc_ret2),
        .out_valid(out_valid2), .out_ready(out_ready),
        .out_instr(out_instr2), .out_pc(out_pc2), .busy(busy2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model (dut only) ----------------
    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    ent_t        mq[$];
    int unsigned m_pc;
    int          m_mode;      // 0 idle, 1 running, 2 halted
    logic        m_redir;
    logic        m_pop;
    logic        m_fen;

    always @(negedge clk) begin
        if (!rstn) begin
            mq.delete();
            m_pc   = 0;
            m_mode = 0;
        end else begin
            m_redir = trap_valid || br_valid;
            m_pop   = (mq.size() > 0) && out_ready;
            m_fen   = (m_mode == 1) && !m_redir && ((mq.size() < DEPTH) || m_pop);

            chk("fetch_en",  {31'd0, fetch_en},  {31'd0, m_fen});
            chk("fetch_pc",  fetch_pc,           m_pc);
            chk("out_valid", {31'd0, out_valid}, {31'd0, mq.size() > 0});
            chk("busy",      {31'd0, busy},      {31'd0, (m_mode == 1) || (mq.size() > 0)});
            if (mq.size() > 0) begin
                chk("out_pc",    out_pc,    mq[0].pc);
                chk("out_instr", out_instr, mq[0].instr);
            end

            if (m_pop) mq.delete(0);
            if (m_redir) begin
                mq.delete();
                m_pc = (trap_valid ? trap_pc : br_pc) % WORDS;
            end else if (m_fen) begin
                mq.push_back('{pc: m_pc, instr: imem[m_pc]});
                m_pc = (m_pc + 1) % WORDS;
            end

            if (m_mode == 0 && start)                     m_mode = 1;
            else if (m_mode == 1 && halt_req && !m_redir) m_mode = 2;
            else if (m_mode == 2 && m_redir)              m_mode = 1;
        end
    end

    // ---------------- stimulus + literal checks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        start = 0; halt_req = 0; trap_valid = 0; br_valid = 0;
        trap_pc = '0; br_pc = '0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_fetch_en"},  {31'd0, fetch_en},  32'd0);
        chk({tag, "_fetch_pc"},  fetch_pc,           32'd0);
        chk({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
        chk({tag, "_out_pc"},    out_pc,             32'd0);
        chk({tag, "_out_instr"}, out_instr,          32'd0);
        chk({tag, "_busy"},      {31'd0, busy},      32'd0);
        chk({tag, "_fetch_pc2"}, fetch_pc2,          32'd62);
    endtask

    initial begin
        bit found;
        for (int i = 0; i < int'(WORDS); i++) imem[i] = $urandom;
        idle_inputs();
        out_ready = 0;
        rstn = 1;
        #1 rstn = 0;
        repeat (3) tick();
        chk_reset_outputs("rst0");

        // A: streaming from reset, out_ready=1
        rstn = 1; start = 1; out_ready = 1;     // cycle 0
        tick(); start = 0;                      // cycle 1
        chk("a_fetch_pc_c1", fetch_pc, 32'd0);
        for (int k = 0; k < 5; k++) begin       // cycles 2..6
            tick();
            chk("a_out_pc",    out_pc,    k);
            chk("a_out_instr", out_instr, imem[k]);
            if (k < 4) chk("wrap_out_pc", out_pc2, (62 + k) % 64);
        end

        // B: back-pressure fills the buffer
        rstn = 0; #1;
        chk_reset_outputs("rst1");
        tick();
        rstn = 1; start = 1; out_ready = 0;     // cycle 0
        tick(); start = 0;                      // cycle 1
        tick();                                 // cycle 2
        for (int c = 3; c <= 5; c++) begin
            tick();
            chk("b_stall_en", {31'd0, fetch_en}, 32'd0);
            chk("b_stall_pc", fetch_pc, 32'd2);
        end
        for (int k = 0; k < 3; k++) begin       // cycles 6..8
            tick();
            out_ready = 1; #1;
            chk("b_drain_pc", out_pc, k);
        end

        // C: trap and branch together while full
        out_ready = 0;
        repeat (3) tick();
        trap_valid = 1; trap_pc = 32'd47; br_valid = 1; br_pc = 32'd20;
        tick();
        idle_inputs(); out_ready = 1; #1;
        chk("c_valid_low", {31'd0, out_valid}, 32'd0);
        chk("c_fetch_pc",  fetch_pc, 32'd47);
        tick();
        chk("c_out_pc",    out_pc, 32'd47);

        // D: halt at pc 5, drain, branch restart
        found = 0;
        for (int i = 0; i < 100 && !found; i++) begin
            tick();
            if (fetch_pc == 32'd5) found = 1;
        end
        chk("d_reach_pc5", fetch_pc, 32'd5);
        halt_req = 1;
        tick(); halt_req = 0;
        repeat (4) tick();
        chk("d_valid_low", {31'd0, out_valid}, 32'd0);
        chk("d_busy_low",  {31'd0, busy},      32'd0);
        chk("d_en_low",    {31'd0, fetch_en},  32'd0);
        br_valid = 1; br_pc = 32'd36;
        tick(); br_valid = 0; #1;
        chk("d_fetch_pc", fetch_pc, 32'd36);
        tick();
        chk("d_out_pc",   out_pc,   32'd36);

        // E: randomized traffic
        for (int i = 0; i < 400; i++) begin
            tick();
            out_ready  = ($urandom_range(9) < 7);
            trap_valid = ($urandom_range(99) < 3);
            br_valid   = ($urandom_range(99) < 5);
            halt_req   = ($urandom_range(99) < 3);
            start      = ($urandom_range(99) < 5);
            trap_pc    = $urandom_range(127);
            br_pc      = $urandom_range(127);
        end

        // F: asynchronous reset with a full buffer
        tick();
        idle_inputs(); br_valid = 1; br_pc = 32'd10;
        tick();
        idle_inputs(); out_ready = 0;
        repeat (4) tick();
        chk("f_full_valid", {31'd0, out_valid}, 32'd1);
        #2 rstn = 0; #1;
        chk_reset_outputs("rst2");
        repeat (2) tick();
        rstn = 1; out_ready = 1;
        repeat (3) begin
            tick();
            chk("f_idle_en",    {31'd0, fetch_en},  32'd0);
            chk("f_idle_valid", {31'd0, out_valid}, 32'd0);
        end
        start = 1;
        tick(); start = 0; #1;
        chk("f_restart_en", {31'd0, fetch_en}, 32'd1);
        chk("f_restart_pc", fetch_pc, 32'd0);
        repeat (3) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
